jk_cmd_seq: RTL and testbench
=============================

Name: jk_cmd_seq

Overview:
- Command sequencer directly upstream of the JK flip-flop stage.
- Accepts set/reset/toggle/hold commands over a valid/ready handshake and buffers them in a small FIFO.
- Drives the flop's j/k inputs for a programmed number of cycles per command.
- Keeps a shadow model of the flop's q so the controlling logic and the bench can check the downstream state.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- CNT_W, 4, width of the per-command hold length.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  command present.
- in_ready  output  1  FIFO can accept a command.
- in_cmd  input  2  00 hold (j=0,k=0); 01 reset (j=0,k=1); 10 set (j=1,k=0); 11 toggle (j=1,k=1).
- in_len  input  CNT_W  cycles to drive the command; 0 is treated as 1.
- j  output  1  registered J drive to the flop.
- k  output  1  registered K drive to the flop.
- busy  output  1  state==DRIVE or FIFO non-empty.
- q_model  output  1  predicted flop output after the current edge.

Behaviour:
- Reset (rst_n low, async):
  - FIFO flushed; pointers and count = 0.
  - state = IDLE; j = k = 0; q_model = 0; down-counter = 0.
  - in_ready = 1 once rst_n is high; busy = 0.
  - An in-flight command is abandoned and is not resumed.
- Push: occurs on a rising edge when in_valid && in_ready.
  - in_ready = (count != DEPTH), decoded combinationally from the registered count.
- Full: in_ready = 0 even if a pop occurs the same cycle. No push-through when full.
- Simultaneous push and pop (not full): both happen; count is unchanged; pointers wrap modulo DEPTH.
- State IDLE: j = k = 0.
  - If the FIFO is non-empty at the edge: pop the head, register j/k from its cmd, load counter = max(len,1), go to DRIVE.
- State DRIVE: j/k held constant; counter decrements every edge.
  - At the edge where counter==1 with the FIFO non-empty: pop the next command and load it. This is back-to-back with no j=k=0 gap cycle.
  - At the edge where counter==1 with the FIFO empty: go to IDLE and set j = k = 0 at that edge.
- Latency: a command pushed at edge N into an empty FIFO in IDLE is popped at edge N+1. Its j/k are visible after edge N+1 for exactly max(len,1) cycles.
- q_model: at every rising edge out of reset, q_model <= JK(j,k,q_model) using the pre-edge j/k:
  - 00 keep.
  - 01 -> 0.
  - 10 -> 1.
  - 11 -> ~q_model.
  - This matches the downstream flop sampling j/k on the same edge.
- Never produces an undefined or unknown j/k value. No pop from an empty FIFO. Commands are executed strictly in push order.

Optional Feature:
- Macro: JK_CMD_SEQ_STATS_EN.
- When defined, adds output port cmd_done (16 bits, reset 0). It increments at each edge where a command finishes (counter==1 in DRIVE), saturates at 0xFFFF, and is cleared by rst_n.
- When not defined, the port and counter do not exist and all other behaviour is identical.

Test Plan:
- Reset then idle: rst_n low 3 cycles, release, no valid -> j=k=0, q_model=0, in_ready=1, busy=0 for 10 cycles.
- Single set: push cmd=10, len=3 at edge N -> j=1,k=0 for edges N+1..N+3. j=k=0 after edge N+4. q_model=1 from edge N+2 onward.
- Back-to-back toggle: push 11/len=2 then 11/len=1 on consecutive cycles -> j=k=1 for 3 contiguous cycles with no gap; q_model sequence 1,0,1 then holds 1.
- Full FIFO: hold in_valid with DEPTH+2 commands of len=5 -> in_ready drops after 4 accepted pushes plus the one popped (count==DEPTH); extra commands are not lost; all execute in order.
- len=0 and hold: push 00/len=0 then 01/len=0 -> one cycle j=k=0 in DRIVE (busy=1), then one cycle j=0,k=1; q_model=0.
- Reset mid-DRIVE: assert rst_n during a 10/len=8 command at cycle 3 -> j,k,q_model drop to 0 asynchronously; FIFO empty; command not resumed after release.

Source files
------------

// File: rtl/jk_cmd_if.sv
// jk_cmd_if: command handshake bundle feeding jk_cmd_seq.
//   in_valid  master->slave  command present
//   in_ready  slave->master  sequencer FIFO can accept a command
//   in_cmd    master->slave  00 hold, 01 reset, 10 set, 11 toggle ({j,k})
//   in_len    master->slave  cycles to drive the command (0 behaves as 1)
interface jk_cmd_if #(
  parameter int CNT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_cmd;
  logic [CNT_W-1:0] in_len;

  modport master (output in_valid, in_cmd, in_len, input  in_ready);
  modport slave  (input  in_valid, in_cmd, in_len, output in_ready);
endinterface

// File: rtl/jk_cmd_seq.sv
// jk_cmd_seq: command sequencer in front of the JK flip-flop stage.
// Buffers set/reset/toggle/hold commands in a DEPTH-entry FIFO and drives the
// flop's j/k for max(len,1) cycles per command, back-to-back when queued.
// q_model tracks the downstream flop output using the same pre-edge j/k.
// Ports:
//   clk, rst_n  clock (rising edge) and asynchronous active-low reset
//   cmd         jk_cmd_if.slave command handshake (valid/ready/cmd/len)
//   j, k        registered J/K drive to the flop
//   busy        DRIVE in progress or FIFO holds a command
//   q_model     predicted flop output after the current edge
//   cmd_done    (only with JK_CMD_SEQ_STATS_EN) saturating count of finished commands
module jk_cmd_seq #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  jk_cmd_if.slave   cmd,
  output logic      j,
  output logic      k,
  output logic      busy,
  output logic      q_model
`ifdef JK_CMD_SEQ_STATS_EN
  ,output logic [15:0] cmd_done
`endif
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [1:0]       cmd;
    logic [CNT_W-1:0] len;
  } ent_t;

  typedef enum logic {IDLE, DRIVE} state_t;

  ent_t             mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             j_n, k_n;
  logic             push, pop, done, empty;
  ent_t             head;

  // Ready depends only on the registered count: a pop in the same cycle
  // does not open a slot when full.
  assign cmd.in_ready = (count != (AW+1)'(DEPTH));
  assign push  = cmd.in_valid && cmd.in_ready;
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];
  assign busy  = (state == DRIVE) || !empty;

  // FIFO storage and pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{cmd: cmd.in_cmd, len: cmd.in_len};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      j     <= 1'b0;
      k     <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      j     <= j_n;
      k     <= k_n;
    end
  end

  // Next state: load from the FIFO head whenever a slot opens (IDLE, or the
  // last cycle of a DRIVE) so queued commands run with no j=k=0 gap.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    j_n     = j;
    k_n     = k;
    pop     = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: begin
        j_n   = 1'b0;
        k_n   = 1'b0;
        cnt_n = '0;
        if (!empty) begin
          pop     = 1'b1;
          state_n = DRIVE;
          {j_n, k_n} = head.cmd;
          cnt_n   = (head.len == '0) ? CNT_W'(1) : head.len;
        end
      end
      DRIVE: begin
        if (cnt == CNT_W'(1)) begin
          done = 1'b1;
          if (!empty) begin
            pop        = 1'b1;
            {j_n, k_n} = head.cmd;
            cnt_n      = (head.len == '0) ? CNT_W'(1) : head.len;
          end else begin
            state_n = IDLE;
            j_n     = 1'b0;
            k_n     = 1'b0;
            cnt_n   = '0;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Shadow of the downstream flop: samples the same pre-edge j/k it does.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_model <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   q_model <= 1'b0;
        2'b10:   q_model <= 1'b1;
        2'b11:   q_model <= ~q_model;
        default: q_model <= q_model;
      endcase
    end
  end

`ifdef JK_CMD_SEQ_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         cmd_done <= '0;
    else if (done && cmd_done != 16'hFFFF) cmd_done <= cmd_done + 16'd1;
  end
`else
  logic unused_done;
  assign unused_done = done;
`endif
endmodule

// File: tb/tb_jk_cmd_seq.sv
module tb_jk_cmd_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic j, k, busy, q_model;
  int   checks = 0;
  int   errors = 0;
`ifdef JK_CMD_SEQ_STATS_EN
  logic [15:0] cmd_done;
`endif

  jk_cmd_if #(.CNT_W(4)) bus ();

  jk_cmd_seq #(.DEPTH(4), .CNT_W(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cmd     (bus),
    .j       (j),
    .k       (k),
    .busy    (busy),
    .q_model (q_model)
`ifdef JK_CMD_SEQ_STATS_EN
    ,.cmd_done (cmd_done)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    bus.in_valid = 1'b0;
    bus.in_cmd   = 2'b00;
    bus.in_len   = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({j, k, q_model, busy, bus.in_ready} !== 5'b00001) begin
        errors++;
        $display("FAIL reset_idle cyc%0d jkqb_rdy=%b exp=00001", i, {j, k, q_model, busy, bus.in_ready});
      end
    end
  endtask

  task automatic test_single_set;
    logic [3:0] exp_v [6] = '{4'b0001, 4'b1001, 4'b1011, 4'b1011, 4'b0010, 4'b0010};
    do_reset();
    bus.in_valid = 1'b1; bus.in_cmd = 2'b10; bus.in_len = 4'd3;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 0) bus.in_valid = 1'b0;
      checks++;
      if ({j, k, q_model, busy} !== exp_v[i]) begin
        errors++;
        $display("FAIL single_set cyc%0d jkqb=%b exp=%b", i, {j, k, q_model, busy}, exp_v[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] exp_v [6] = '{4'b0001, 4'b1101, 4'b1111, 4'b1101, 4'b0010, 4'b0010};
    do_reset();
    bus.in_valid = 1'b1; bus.in_cmd = 2'b11; bus.in_len = 4'd2;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 0) bus.in_len = 4'd1;
      if (i == 1) bus.in_valid = 1'b0;
      checks++;
      if ({j, k, q_model, busy} !== exp_v[i]) begin
        errors++;
        $display("FAIL back_to_back cyc%0d jkqb=%b exp=%b", i, {j, k, q_model, busy}, exp_v[i]);
      end
    end
  endtask

  task automatic test_full;
    logic [1:0] cmds  [6] = '{2'b10, 2'b01, 2'b11, 2'b00, 2'b10, 2'b01};
    logic       rdy_e [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [1:0] exp_jk;
    logic       acc;
    int         idx = 0;
    do_reset();
    bus.in_valid = 1'b1; bus.in_cmd = cmds[0]; bus.in_len = 4'd5;
    for (int e = 1; e <= 33; e++) begin
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      tick();
      if (acc) idx++;
      if (idx >= 6) bus.in_valid = 1'b0;
      else          bus.in_cmd   = cmds[idx];
      if (e <= 8) begin
        checks++;
        if (bus.in_ready !== rdy_e[e-1]) begin
          errors++;
          $display("FAIL full_ready edge%0d got=%b exp=%b", e, bus.in_ready, rdy_e[e-1]);
        end
      end
      exp_jk = (e >= 2 && e <= 31) ? cmds[(e-2)/5] : 2'b00;
      checks++;
      if ({j, k, busy} !== {exp_jk, (e <= 31)}) begin
        errors++;
        $display("FAIL full_order edge%0d jkb=%b exp=%b", e, {j, k, busy}, {exp_jk, (e <= 31)});
      end
    end
    checks++;
    if (idx != 6) begin
      errors++;
      $display("FAIL full_accepted got=%0d exp=6", idx);
    end
`ifdef JK_CMD_SEQ_STATS_EN
    checks++;
    if (cmd_done !== 16'd6) begin
      errors++;
      $display("FAIL cmd_done got=%0d exp=6", cmd_done);
    end
`endif
  endtask

  task automatic test_len0_hold;
    logic [3:0] exp_v [5] = '{4'b0001, 4'b0001, 4'b0101, 4'b0000, 4'b0000};
    do_reset();
    bus.in_valid = 1'b1; bus.in_cmd = 2'b00; bus.in_len = 4'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) bus.in_cmd = 2'b01;
      if (i == 1) bus.in_valid = 1'b0;
      checks++;
      if ({j, k, q_model, busy} !== exp_v[i]) begin
        errors++;
        $display("FAIL len0_hold cyc%0d jkqb=%b exp=%b", i, {j, k, q_model, busy}, exp_v[i]);
      end
    end
  endtask

  task automatic test_reset_mid_drive;
    do_reset();
    bus.in_valid = 1'b1; bus.in_cmd = 2'b10; bus.in_len = 4'd8;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 0) bus.in_valid = 1'b0;
    end
    checks++;
    if ({j, k, q_model, busy} !== 4'b1011) begin
      errors++;
      $display("FAIL mid_drive_pre jkqb=%b exp=1011", {j, k, q_model, busy});
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({j, k, q_model, busy, bus.in_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL mid_drive_async jkqb_rdy=%b exp=00001", {j, k, q_model, busy, bus.in_ready});
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({j, k, q_model, busy, bus.in_ready} !== 5'b00001) begin
        errors++;
        $display("FAIL mid_drive_after cyc%0d jkqb_rdy=%b exp=00001", i, {j, k, q_model, busy, bus.in_ready});
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_set();
    test_back_to_back();
    test_full();
    test_len0_hold();
    test_reset_mid_drive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
